cic_comb_multi: RTL and testbench

Parametrised multi-stage, multi-channel CIC comb section. It computes NUM_STAGES cascaded differences y[n] = x[n] − x[n−M] independently per channel, with a run-time differential delay M. Samples of different channels are time-interleaved on one AXI-stream and tagged by tuser. It sits between the integrator chain/decimator and the CIC compensation filter, and replaces the single-stage, single-channel, fixed-depth comb.

---
 rtl/cic_comb_pkg.sv | 24 ++
 rtl/cic_comb_stage.sv | 160 ++++++++++++++++
 rtl/cic_comb_multi.sv | 84 ++++++++
 tb/tb_cic_comb_multi.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_comb_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel CIC comb.
// Pure package: no logic, no latency, no flow control.
package cic_comb_pkg;

    localparam int COMB_STAGE_LATENCY = 3;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // tuser is at least one bit wide even for a single channel
    function automatic int tuser_w(input int chan_log2);
        return (chan_log2 > 1) ? chan_log2 : 1;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb stage y = x - x[n-M] per channel, history RAM addressed {chan, ptr}; latency 3 cycles.
// No backpressure: one sample per cycle; valid, tuser, M and the prime-clear marker ride along.
module cic_comb_stage
    import cic_comb_pkg::*;
#(
    parameter int DATA_WIDTH = 48,
    parameter int DELAY_LOG2 = 9,
    parameter int CHAN_LOG2  = 0
) (
    input  logic                          clk,
    input  logic                          sync_reset,
    input  logic                          in_vld,
    input  logic [DATA_WIDTH-1:0]         in_dat,
    input  logic [tuser_w(CHAN_LOG2)-1:0] in_usr,
    input  logic [DELAY_LOG2-1:0]         in_m,
    input  logic                          in_clr,
    output logic                          out_vld,
    output logic [DATA_WIDTH-1:0]         out_dat,
    output logic [tuser_w(CHAN_LOG2)-1:0] out_usr,
    output logic [DELAY_LOG2-1:0]         out_m,
    output logic                          out_clr
);
    localparam int LAT     = COMB_STAGE_LATENCY;
    localparam int TUSER_W = tuser_w(CHAN_LOG2);
    localparam int NCH     = 1 << CHAN_LOG2;
    localparam int HIST    = 1 << DELAY_LOG2;
    localparam int DEPTH   = NCH * HIST;
    localparam int ADDR_W  = clog2(DEPTH);

    logic [DELAY_LOG2-1:0] ptr_q   [NCH];
    logic [DELAY_LOG2-1:0] ptr_d   [NCH];
    logic [DELAY_LOG2-1:0] prime_q [NCH];
    logic [DELAY_LOG2-1:0] prime_d [NCH];

    logic                  vld_q [LAT];
    logic                  vld_d [LAT];
    logic [TUSER_W-1:0]    usr_q [LAT];
    logic [TUSER_W-1:0]    usr_d [LAT];
    logic [DELAY_LOG2-1:0] m_q   [LAT];
    logic [DELAY_LOG2-1:0] m_d   [LAT];
    logic                  clr_q [LAT];
    logic                  clr_d [LAT];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] dat1_q, dat1_d, dat2_q, dat2_d;
    logic [DATA_WIDTH-1:0] rd_dat_q, rd_dat_d, res_q, res_d;
    logic                  use1_q, use1_d, use2_q, use2_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;

    logic [TUSER_W-1:0]    chan;
    logic [DELAY_LOG2-1:0] ptr_cur, prime_cur, rd_ptr;
    logic                  use_hist;
    logic [ADDR_W-1:0]     wr_addr, rd_addr;

    assign chan      = (CHAN_LOG2 == 0) ? '0 : in_usr;
    assign ptr_cur   = ptr_q[chan];
    // A pending clear applies to the sample arriving alongside it
    assign prime_cur = in_clr ? '0 : prime_q[chan];
    assign use_hist  = (in_m != '0) && (prime_cur >= in_m);
    assign rd_ptr    = ptr_cur - in_m;

    generate
        if (CHAN_LOG2 == 0) begin : g_addr_one
            assign wr_addr = ptr_cur;
            assign rd_addr = rd_ptr;
        end else begin : g_addr_multi
            assign wr_addr = {chan, ptr_cur};
            assign rd_addr = {chan, rd_ptr};
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ptr_d[i]   = ptr_q[i];
            prime_d[i] = in_clr ? '0 : prime_q[i];
        end
        if (in_vld) begin
            ptr_d[chan] = ptr_cur + DELAY_LOG2'(1);
            if (prime_cur < in_m) begin
                prime_d[chan] = prime_cur + DELAY_LOG2'(1);
            end
        end
    end

    always_comb begin
        vld_d[0] = in_vld;
        usr_d[0] = in_usr;
        m_d[0]   = in_m;
        clr_d[0] = in_clr;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            usr_d[i] = usr_q[i-1];
            m_d[i]   = m_q[i-1];
            clr_d[i] = clr_q[i-1];
        end
    end

    always_comb begin
        dat1_d    = in_dat;
        use1_d    = use_hist;
        wr_addr_d = wr_addr;
        rd_addr_d = rd_addr;
        dat2_d    = dat1_q;
        use2_d    = use1_q;
        rd_dat_d  = mem[rd_addr_q];
        // Modular subtract: wrap-around is what keeps the CIC exact
        res_d     = dat2_q - (use2_q ? rd_dat_q : '0);
    end

    always_ff @(posedge clk) begin
        if (vld_q[0]) begin
            mem[wr_addr_q] <= dat1_q;
        end
        rd_dat_q <= rd_dat_d;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            for (int i = 0; i < NCH; i++) begin
                ptr_q[i]   <= '0;
                prime_q[i] <= '0;
            end
            for (int i = 0; i < LAT; i++) begin
                vld_q[i] <= 1'b0;
                usr_q[i] <= '0;
                m_q[i]   <= '0;
                clr_q[i] <= 1'b0;
            end
            dat1_q    <= '0;
            dat2_q    <= '0;
            use1_q    <= 1'b0;
            use2_q    <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            res_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            prime_q   <= prime_d;
            vld_q     <= vld_d;
            usr_q     <= usr_d;
            m_q       <= m_d;
            clr_q     <= clr_d;
            dat1_q    <= dat1_d;
            dat2_q    <= dat2_d;
            use1_q    <= use1_d;
            use2_q    <= use2_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            res_q     <= res_d;
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_dat = res_q;
    assign out_usr = usr_q[LAT-1];
    assign out_m   = m_q[LAT-1];
    assign out_clr = clr_q[LAT-1];

endmodule

// File: rtl/cic_comb_multi.sv
// Multi-stage, multi-channel CIC comb with run-time M; latency 3*NUM_STAGES cycles.
// No backpressure: one sample per cycle sustained, channels interleaved by tuser.
module cic_comb_multi
    import cic_comb_pkg::*;
#(
    parameter int DATA_WIDTH = 48,
    parameter int NUM_STAGES = 1,
    parameter int DELAY_LOG2 = 9,
    parameter int CHAN_LOG2  = 0
) (
    input  logic                          clk,
    input  logic                          sync_reset,
    input  logic [DELAY_LOG2-1:0]         msetting,
    input  logic                          s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [tuser_w(CHAN_LOG2)-1:0] s_axis_tuser,
    output logic                          m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [tuser_w(CHAN_LOG2)-1:0] m_axis_tuser
);
    localparam int TUSER_W = tuser_w(CHAN_LOG2);

    logic [DELAY_LOG2-1:0] m_r_q, m_r_d;
    logic                  m_chg_q, m_chg_d;

    always_comb begin
        m_r_d   = msetting;
        m_chg_d = (msetting != m_r_q);
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            m_r_q   <= '0;
            m_chg_q <= 1'b0;
        end else begin
            m_r_q   <= m_r_d;
            m_chg_q <= m_chg_d;
        end
    end

    logic                  vld_c [NUM_STAGES+1];
    logic [DATA_WIDTH-1:0] dat_c [NUM_STAGES+1];
    logic [TUSER_W-1:0]    usr_c [NUM_STAGES+1];
    logic [DELAY_LOG2-1:0] m_c   [NUM_STAGES+1];
    logic                  clr_c [NUM_STAGES+1];

    assign vld_c[0] = s_axis_tvalid;
    assign dat_c[0] = s_axis_tdata;
    assign usr_c[0] = s_axis_tuser;
    assign m_c[0]   = m_r_q;
    // The clear marker travels with the samples so in-flight data keeps its own M
    assign clr_c[0] = m_chg_q;

    generate
        for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
            cic_comb_stage #(
                .DATA_WIDTH (DATA_WIDTH),
                .DELAY_LOG2 (DELAY_LOG2),
                .CHAN_LOG2  (CHAN_LOG2)
            ) u_stage (
                .clk        (clk),
                .sync_reset (sync_reset),
                .in_vld     (vld_c[g]),
                .in_dat     (dat_c[g]),
                .in_usr     (usr_c[g]),
                .in_m       (m_c[g]),
                .in_clr     (clr_c[g]),
                .out_vld    (vld_c[g+1]),
                .out_dat    (dat_c[g+1]),
                .out_usr    (usr_c[g+1]),
                .out_m      (m_c[g+1]),
                .out_clr    (clr_c[g+1])
            );
        end
    endgenerate

    assign m_axis_tvalid = vld_c[NUM_STAGES];
    assign m_axis_tdata  = dat_c[NUM_STAGES];
    assign m_axis_tuser  = usr_c[NUM_STAGES];

    logic unused_tail;
    assign unused_tail = ^{m_c[NUM_STAGES], clr_c[NUM_STAGES]};

endmodule

// File: tb/tb_cic_comb_multi.sv
// Directed bench for cic_comb_multi: an 8-bit 4-channel single-stage instance and
// a 16-bit single-channel three-stage instance, checked against hand-computed tables.
module tb_cic_comb_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       sync_reset;

    logic [3:0] a_mset;
    logic       a_vld;
    logic [7:0] a_dat;
    logic [1:0] a_usr;
    logic       a_m_vld;
    logic [7:0] a_m_dat;
    logic [1:0] a_m_usr;

    logic [3:0]  b_mset;
    logic        b_vld;
    logic [15:0] b_dat;
    logic        b_usr;
    logic        b_m_vld;
    logic [15:0] b_m_dat;
    logic        b_m_usr;

    cic_comb_multi #(.DATA_WIDTH(8), .NUM_STAGES(1), .DELAY_LOG2(4), .CHAN_LOG2(2)) dut_a (
        .clk           (clk),
        .sync_reset    (sync_reset),
        .msetting      (a_mset),
        .s_axis_tvalid (a_vld),
        .s_axis_tdata  (a_dat),
        .s_axis_tuser  (a_usr),
        .m_axis_tvalid (a_m_vld),
        .m_axis_tdata  (a_m_dat),
        .m_axis_tuser  (a_m_usr)
    );

    cic_comb_multi #(.DATA_WIDTH(16), .NUM_STAGES(3), .DELAY_LOG2(4), .CHAN_LOG2(0)) dut_b (
        .clk           (clk),
        .sync_reset    (sync_reset),
        .msetting      (b_mset),
        .s_axis_tvalid (b_vld),
        .s_axis_tdata  (b_dat),
        .s_axis_tuser  (b_usr),
        .m_axis_tvalid (b_m_vld),
        .m_axis_tdata  (b_m_dat),
        .m_axis_tuser  (b_m_usr)
    );

    logic [7:0]  qa_dat[$];
    logic [1:0]  qa_usr[$];
    int          qa_cyc[$];
    logic [15:0] qb_dat[$];
    logic        qb_usr[$];
    int          qb_cyc[$];

    always @(negedge clk) begin
        if (a_m_vld) begin
            qa_dat.push_back(a_m_dat);
            qa_usr.push_back(a_m_usr);
            qa_cyc.push_back(cyc);
        end
        if (b_m_vld) begin
            qb_dat.push_back(b_m_dat);
            qb_usr.push_back(b_m_usr);
            qb_cyc.push_back(cyc);
        end
    end

    int n_chk = 0;
    int n_err = 0;
    longint exp_d[$];
    longint exp_u[$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        qa_dat.delete(); qa_usr.delete(); qa_cyc.delete();
        qb_dat.delete(); qb_usr.delete(); qb_cyc.delete();
        exp_d.delete();  exp_u.delete();
    endtask

    task automatic send_a(input int d, input int u);
        a_vld = 1'b1;
        a_dat = 8'(d);
        a_usr = 2'(u);
        tick();
        a_vld = 1'b0;
    endtask

    task automatic send_b(input int d);
        b_vld = 1'b1;
        b_dat = 16'(d);
        tick();
        b_vld = 1'b0;
    endtask

    task automatic fill_u(input int u);
        exp_u.delete();
        for (int i = 0; i < exp_d.size(); i++) exp_u.push_back(u);
    endtask

    task automatic cmp_a(input string tag, input int t0);
        chk({tag, "_cnt"}, qa_dat.size(), exp_d.size());
        if (qa_cyc.size() > 0) chk({tag, "_lat"}, qa_cyc[0] - t0, 3);
        for (int i = 0; i < exp_d.size() && i < qa_dat.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), longint'($signed(qa_dat[i])), exp_d[i]);
            chk($sformatf("%s_u%0d", tag, i), qa_usr[i], exp_u[i]);
        end
    endtask

    task automatic cmp_b(input string tag, input int t0);
        chk({tag, "_cnt"}, qb_dat.size(), exp_d.size());
        if (qb_cyc.size() > 0) chk({tag, "_lat"}, qb_cyc[0] - t0, 9);
        for (int i = 0; i < exp_d.size() && i < qb_dat.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), longint'($signed(qb_dat[i])), exp_d[i]);
            chk($sformatf("%s_u%0d", tag, i), qb_usr[i], 0);
        end
    endtask

    function automatic int ramp(input int k, input int c);
        case (c)
            0:       return k;
            1:       return 10 * k;
            2:       return -k;
            default: return 0;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish within 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int steady[4];
        steady = '{3, 30, -3, 0};

        sync_reset = 1'b1;
        a_mset = 4'd4; a_vld = 1'b0; a_dat = '0; a_usr = '0;
        b_mset = 4'd2; b_vld = 1'b0; b_dat = '0; b_usr = 1'b0;
        repeat (3) tick();
        chk("rst_a_vld", a_m_vld, 0);
        chk("rst_a_dat", a_m_dat, 0);
        chk("rst_a_usr", a_m_usr, 0);
        chk("rst_b_vld", b_m_vld, 0);
        chk("rst_b_dat", b_m_dat, 0);
        chk("rst_b_usr", b_m_usr, 0);
        sync_reset = 1'b0;
        repeat (3) tick();

        // Step through three stages, M=2: (1 - z^-2)^3 applied to a constant 5
        clear_q();
        t0 = cyc;
        repeat (10) send_b(5);
        repeat (12) tick();
        exp_d = '{5, 5, -10, -10, 5, 5, 0, 0, 0, 0};
        cmp_b("step", t0);

        // M=0: three stages of pure delay, with a gap in tvalid
        b_mset = 4'd0;
        repeat (3) tick();
        clear_q();
        t0 = cyc;
        send_b(3);
        tick();
        send_b(-4);
        send_b(7);
        repeat (12) tick();
        exp_d = '{3, -4, 7};
        cmp_b("m0", t0);

        // Impulse, M=4, channel 0
        clear_q();
        t0 = cyc;
        send_a(1, 0);
        repeat (7) send_a(0, 0);
        repeat (6) tick();
        exp_d = '{1, 0, 0, 0, -1, 0, 0, 0};
        fill_u(0);
        cmp_a("imp", t0);

        // Four interleaved ramps, M=3
        a_mset = 4'd3;
        repeat (3) tick();
        clear_q();
        t0 = cyc;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 4; c++) begin
                send_a(ramp(k, c), c);
                exp_d.push_back((k < 3) ? ramp(k, c) : steady[c]);
                exp_u.push_back(c);
            end
        end
        repeat (6) tick();
        cmp_a("ilv", t0);

        // Wrap at 8 bits, M=1 back-to-back on channel 1
        a_mset = 4'd1;
        repeat (3) tick();
        clear_q();
        t0 = cyc;
        send_a(127, 1);
        send_a(-128, 1);
        send_a(0, 1);
        repeat (6) tick();
        exp_d = '{127, 1, -128};
        fill_u(1);
        cmp_a("wrap", t0);

        // M 4 -> 8 coincident with sample 10 on channel 3, constant 7
        a_mset = 4'd4;
        repeat (3) tick();
        clear_q();
        t0 = cyc;
        for (int i = 0; i < 21; i++) begin
            if (i == 10) a_mset = 4'd8;
            send_a(7, 3);
        end
        repeat (6) tick();
        exp_d = '{7, 7, 7, 7, 0, 0, 0, 0, 0, 0, 0,
                  7, 7, 7, 7, 7, 7, 7, 7, 0, 0};
        fill_u(3);
        cmp_a("mchg", t0);

        // Reset in the middle of a burst, M=2, channel 0
        a_mset = 4'd2;
        repeat (3) tick();
        clear_q();
        repeat (6) send_a(9, 0);
        sync_reset = 1'b1;
        a_vld = 1'b1;
        a_dat = 8'd9;
        tick();
        chk("rst_mid_vld", a_m_vld, 0);
        chk("rst_mid_pre_cnt", qa_dat.size(), 4);
        sync_reset = 1'b0;
        a_vld = 1'b0;
        repeat (5) tick();
        chk("rst_mid_quiet_cnt", qa_dat.size(), 4);
        clear_q();
        t0 = cyc;
        repeat (4) send_a(5, 0);
        repeat (6) tick();
        exp_d = '{5, 5, 0, 0};
        fill_u(0);
        cmp_a("post_rst", t0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
